// File: rtl/lsu.sv
// Load/store unit: one aligned access per request over a single-outstanding
// valid/ready memory port, with local misalignment detection and load extension.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [63:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic        out_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;

  logic [2:0]  in_off;
  logic        in_mis;
  logic [7:0]  in_mask;
  logic [63:0] ld_shift;
  logic [63:0] ld_ext;

  assign in_off = in_addr[2:0];

  always_comb begin
    in_mis  = 1'b0;
    in_mask = 8'h00;
    case (in_size)
      2'd0: begin in_mis = 1'b0;           in_mask = 8'h01 << in_off; end
      2'd1: begin in_mis = in_off[0];      in_mask = 8'h03 << in_off; end
      2'd2: begin in_mis = |in_off[1:0];   in_mask = 8'h0F << in_off; end
      default: begin in_mis = |in_off;     in_mask = 8'hFF;           end
    endcase
  end

  // Bring the addressed lane down to bit 0, then truncate and extend by size.
  always_comb begin
    ld_shift = mem_resp_rdata >> {addr_q[2:0], 3'b000};
    ld_ext   = '0;
    case (size_q)
      2'd0: ld_ext = uns_q ? {56'd0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      2'd1: ld_ext = uns_q ? {48'd0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_ext = uns_q ? {32'd0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wen_d   = in_wen;
          size_d  = in_size;
          uns_d   = in_unsigned;
          addr_d  = in_addr;
          wmask_d = in_wen ? in_mask : 8'h00;
          wdata_d = in_wdata << {in_off, 3'b000};
          rdata_d = '0;
          mis_d   = in_mis;
          state_d = in_mis ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          rdata_d = wen_q ? '0 : ld_ext;
          state_d = S_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = {addr_q[63:3], 3'b000};
  assign mem_wen       = wen_q;
  assign mem_wmask     = wmask_q;
  assign mem_wdata     = wdata_q;
  assign out_valid     = (state_q == S_DONE);
  assign out_rdata     = rdata_q;
  assign out_misalign  = mis_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: aligned loads/stores, misalignment, backpressure
// and reset in the middle of a transaction.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic        out_misalign;

  int unsigned tests;
  int unsigned fails;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_misalign(out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    in_valid = 1'b1; in_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata;
    tick();
    in_valid = 1'b0;
  endtask

  // Full aligned transaction with zero-wait memory; checks request fields,
  // the N+3 result timing and the return to IDLE.
  task automatic run_aligned(input string tag, input logic wen, input logic [1:0] size,
                             input logic uns, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [63:0] rdata,
                             input logic [7:0] exp_mask, input logic [63:0] lane_bits,
                             input logic [63:0] exp_lane_data, input logic [63:0] exp_rdata);
    mem_req_ready = 1'b1;
    issue(wen, size, uns, addr, wdata);
    chk({tag, ".req_valid"}, mem_req_valid, 1);
    chk({tag, ".in_ready_busy"}, in_ready, 0);
    chk({tag, ".addr"}, mem_addr, {addr[63:3], 3'b000});
    chk({tag, ".wen"}, mem_wen, wen);
    chk({tag, ".wmask"}, mem_wmask, exp_mask);
    chk({tag, ".wdata"}, mem_wdata & lane_bits, exp_lane_data);
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    chk({tag, ".req_drop"}, mem_req_valid, 0);
    chk({tag, ".no_early_out"}, out_valid, 0);
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".rdata"}, out_rdata, exp_rdata);
    chk({tag, ".misalign"}, out_misalign, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".idle"}, in_ready, 1);
    chk({tag, ".out_clear"}, out_valid, 0);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = '0; out_ready = 1'b0;
    tick(); tick();

    chk("rst.in_ready", in_ready, 1);
    chk("rst.req_valid", mem_req_valid, 0);
    chk("rst.wen", mem_wen, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.misalign", out_misalign, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wmask", mem_wmask, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.rdata", out_rdata, 0);
    rst_n = 1'b1;
    tick();

    run_aligned("ld_d", 0, 2'd3, 0, 64'h8000_0008, 64'h0, 64'h1122_3344_5566_7788,
                8'h00, 64'h0, 64'h0, 64'h1122_3344_5566_7788);
    run_aligned("ld_bs", 0, 2'd0, 0, 64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000,
                8'h00, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
    run_aligned("ld_bu", 0, 2'd0, 1, 64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000,
                8'h00, 64'h0, 64'h0, 64'h0000_0000_0000_0080);
    run_aligned("ld_ws", 0, 2'd2, 0, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000,
                8'h00, 64'h0, 64'h0, 64'hFFFF_FFFF_89AB_CDEF);
    run_aligned("ld_hu", 0, 2'd1, 1, 64'h8000_0002, 64'h0, 64'h0000_0000_F00D_0000,
                8'h00, 64'h0, 64'h0, 64'h0000_0000_0000_F00D);
    run_aligned("st_h", 1, 2'd1, 0, 64'h8000_0006, 64'hABCD, 64'h5555_5555_5555_5555,
                8'hC0, 64'hFFFF_0000_0000_0000, 64'hABCD_0000_0000_0000, 64'h0);
    run_aligned("st_b", 1, 2'd0, 0, 64'h8000_0003, 64'h5A, 64'h0,
                8'h08, 64'h0000_0000_FF00_0000, 64'h0000_0000_5A00_0000, 64'h0);

    // Misaligned word right after a load that left out_rdata nonzero.
    run_aligned("ld_pre", 0, 2'd0, 1, 64'h8000_0000, 64'h0, 64'h0000_0000_0000_00C3,
                8'h00, 64'h0, 64'h0, 64'h0000_0000_0000_00C3);
    mem_req_ready = 1'b1;
    issue(0, 2'd2, 0, 64'h8000_0002, 64'h0);
    chk("mis.out_valid", out_valid, 1);
    chk("mis.flag", out_misalign, 1);
    chk("mis.rdata", out_rdata, 0);
    chk("mis.req_valid", mem_req_valid, 0);
    chk("mis.in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mis.req_after", mem_req_valid, 0);
    chk("mis.idle", in_ready, 1);
    mem_req_ready = 1'b0;

    // Backpressure on both memory request and write-back.
    issue(1, 2'd2, 0, 64'h8000_0004, 64'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      chk("bp.req_valid", mem_req_valid, 1);
      chk("bp.addr", mem_addr, 64'h8000_0000);
      chk("bp.wmask", mem_wmask, 8'hF0);
      chk("bp.wdata", mem_wdata & 64'hFFFF_FFFF_0000_0000, 64'h1234_5678_0000_0000);
      chk("bp.wen", mem_wen, 1);
      chk("bp.in_ready", in_ready, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    chk("bp.resp_wait", out_valid, 0);
    chk("bp.resp_wait_req", mem_req_valid, 0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.out_hold", out_valid, 1);
      chk("bp.out_rdata", out_rdata, 0);
      chk("bp.in_ready_hold", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_wen = 1'b0; in_size = 2'd3; in_addr = 64'h8000_0010;
    chk("bp.in_ready_hs", in_ready, 0);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp.in_ready_after", in_ready, 1);
    chk("bp.no_capture", mem_req_valid, 0);

    // Reset while waiting for the response.
    mem_req_ready = 1'b1;
    issue(0, 2'd3, 0, 64'h8000_0018, 64'h0);
    tick();
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rr.addr", mem_addr, 0);
    chk("rr.in_ready", in_ready, 1);
    chk("rr.out_valid", out_valid, 0);
    chk("rr.req_valid", mem_req_valid, 0);
    tick();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    chk("rr.stale_idle", out_valid, 0);
    chk("rr.stale_in_ready", in_ready, 1);
    chk("rr.stale_rdata", out_rdata, 0);
    in_valid = 1'b1; in_wen = 1'b0; in_size = 2'd2; in_unsigned = 1'b1;
    in_addr = 64'h8000_0020;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rr.stale_req", mem_req_valid, 1);
    chk("rr.stale_req_out", out_valid, 0);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hCAFE_BABE_F000_0001;
    tick();
    mem_resp_valid = 1'b0;
    chk("rr.fresh_valid", out_valid, 1);
    chk("rr.fresh_rdata", out_rdata, 64'h0000_0000_F000_0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rr.fresh_idle", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
